// File: rtl/io_bridge.sv
// io_bridge: memory-mapped I/O for the stack core. It holds an LED register, a UART transmitter fed by a 4-byte FIFO, and a free-running tick counter.
// Latency: writes take effect on the write edge and reads are combinational from io_address. uart_tx falls one clock after a push into an empty, idle transmitter.
// Backpressure: none towards the core. A push to a full FIFO with no pop on the same edge is dropped and sets a sticky overflow flag.
//
// Ports:
//   clock, active_low_reset        : system clock (rising edge); asynchronous active-low reset
//   io_address[15:0]               : full 16-bit decode address (reads and writes)
//   io_write_enable, io_write_data : write strobe and write data from the core
//   io_read_data                   : combinational read data back to the core
//   leds[7:0]                      : LED register
//   uart_tx                        : 8N1 serial output, idle high, registered
//
// Register map:
//   0x1000 LED
//   0x2000 TX data (write-only push)
//   0x2001 TX status {count[5:3], overflow[2], full[1], busy[0]}; any write clears overflow
//   0x3000 tick counter

// Generic FIFO. A push into a full FIFO is accepted when a pop happens on the same edge.
// Latency: the head is visible combinationally on o_rd_dat; a push appears on the edge after it is accepted.
// Backpressure: o_wr_rdy is low only when the FIFO is full and no pop is in progress.
module fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       active_low_reset,
  input  logic                       i_wr_vld,
  input  logic [DW-1:0]              i_wr_dat,
  output logic                       o_wr_rdy,
  input  logic                       i_rd_rdy,
  output logic                       o_rd_vld,
  output logic [DW-1:0]              o_rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_rd_vld = (r_count != '0);
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign w_pop    = i_rd_rdy && o_rd_vld;
  // When the FIFO is full, the write pointer equals the read pointer. A same-edge pop
  // reads the old head before the slot is overwritten, so the write is safe.
  assign o_wr_rdy = (r_count != CW'(DEPTH)) || w_pop;
  assign w_push   = i_wr_vld && o_wr_rdy;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module io_bridge #(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clock,
  input  logic             active_low_reset,
  input  logic [15:0]      io_address,
  input  logic             io_write_enable,
  input  logic [WIDTH-1:0] io_write_data,
  output logic [WIDTH-1:0] io_read_data,
  output logic [7:0]       leds,
  output logic             uart_tx
);
  localparam logic [15:0] ADDR_LED  = 16'h1000;
  localparam logic [15:0] ADDR_TXD  = 16'h2000;
  localparam logic [15:0] ADDR_STAT = 16'h2001;
  localparam logic [15:0] ADDR_TICK = 16'h3000;
  localparam int             BCW      = $clog2(CLKS_PER_BIT);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  logic [7:0]       r_leds;
  logic             r_overflow;
  logic [WIDTH-1:0] r_tick;
  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [BCW-1:0]   r_bit_cnt;
  logic [BCW-1:0]   w_bit_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_tx;
  logic             w_tx_nxt;
  logic             w_bit_end;
  logic             w_pop;
  logic             w_fifo_vld;
  logic [7:0]       w_fifo_dat;
  logic [2:0]       w_fifo_count;
  logic             w_fifo_wr_rdy;
  logic             w_wr_led;
  logic             w_wr_txd;
  logic             w_wr_stat;
  logic             w_wr_tick;
  logic             w_busy;
  logic             w_full;

  assign w_wr_led  = io_write_enable && (io_address == ADDR_LED);
  assign w_wr_txd  = io_write_enable && (io_address == ADDR_TXD);
  assign w_wr_stat = io_write_enable && (io_address == ADDR_STAT);
  assign w_wr_tick = io_write_enable && (io_address == ADDR_TICK);

  fifo #(.DW(8), .DEPTH(4)) u_tx_fifo (
    .clock            (clock),
    .active_low_reset (active_low_reset),
    .i_wr_vld         (w_wr_txd),
    .i_wr_dat         (io_write_data[7:0]),
    .o_wr_rdy         (w_fifo_wr_rdy),
    .i_rd_rdy         (w_pop),
    .o_rd_vld         (w_fifo_vld),
    .o_rd_dat         (w_fifo_dat),
    .o_count          (w_fifo_count)
  );

  assign w_busy = (w_fifo_count != 3'd0) || (r_state != S_IDLE);
  assign w_full = (w_fifo_count == 3'd4);

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      r_leds     <= 8'h00;
      r_overflow <= 1'b0;
      r_tick     <= '0;
    end else begin
      if (w_wr_led) begin
        r_leds <= io_write_data[7:0];
      end
      if (w_wr_stat) begin
        r_overflow <= 1'b0;
      end else if (w_wr_txd && !w_fifo_wr_rdy) begin
        r_overflow <= 1'b1;
      end
      r_tick <= w_wr_tick ? io_write_data : r_tick + 1'b1;
    end
  end

  // Transmitter. Every state lasts CLKS_PER_BIT clocks. The bit counter is cleared
  // on every state change, so each state begins counting at zero.
  assign w_bit_end = (r_bit_cnt == BIT_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    w_tx_nxt      = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_vld) begin
          w_state_nxt   = S_START;
          w_pop         = 1'b1;
          w_shift_nxt   = w_fifo_dat;
          w_bit_cnt_nxt = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
          w_bit_idx_nxt = 3'd0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_bit_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_bit_cnt_nxt = '0;
          // Chain straight into the next start bit so queued bytes go out with no idle gap.
          if (w_fifo_vld) begin
            w_state_nxt = S_START;
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dat;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = '0;
      end
    endcase
    // uart_tx is registered from the next state, so the line changes on the same
    // edge as the state and has no combinational path to the pin.
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  always_comb begin
    io_read_data = '0;
    case (io_address)
      ADDR_LED:  io_read_data = WIDTH'(r_leds);
      ADDR_STAT: io_read_data = WIDTH'({w_fifo_count, r_overflow, w_full, w_busy});
      ADDR_TICK: io_read_data = r_tick;
      default:   io_read_data = '0;
    endcase
  end

  assign leds    = r_leds;
  assign uart_tx = r_tx;
endmodule

// File: tb/tb_io_bridge.sv
// Testbench for io_bridge with CLKS_PER_BIT=4.
// The reference model tracks the FIFO as a queue and the transmitter as a "free at edge N" timestamp.
// A UART receiver process decodes uart_tx and checks each byte against the queue of expected bytes.
module tb_io_bridge;
  localparam int W     = 16;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic         clock = 1'b0;
  logic         active_low_reset = 1'b0;
  logic [15:0]  io_address = 16'h0000;
  logic         io_write_enable = 1'b0;
  logic [W-1:0] io_write_data = '0;
  logic [W-1:0] io_read_data;
  logic [7:0]   leds;
  logic         uart_tx;

  io_bridge #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clock            (clock),
    .active_low_reset (active_low_reset),
    .io_address       (io_address),
    .io_write_enable  (io_write_enable),
    .io_write_data    (io_write_data),
    .io_read_data     (io_read_data),
    .leds             (leds),
    .uart_tx          (uart_tx)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  byte unsigned m_fifo[$];
  byte unsigned exp_q[$];
  logic [7:0]   m_leds;
  logic         m_ovf;
  logic [15:0]  m_tick;
  int           m_cyc;
  int           m_free_at;

  int           epoch = 0;
  int           pcount = 0;
  byte unsigned rx_q[$];
  int           starts_q[$];

  always @(posedge clock) pcount <= pcount + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_leds    = 8'h00;
    m_ovf     = 1'b0;
    m_tick    = 16'h0000;
    m_cyc     = 0;
    m_free_at = -1;
  endtask

  // One rising edge: the transmitter takes the head byte once the previous frame's
  // 10 bit times have elapsed. A push is accepted if there is room after that pop.
  task automatic model_edge(input logic we, input logic [15:0] a, input logic [15:0] d);
    bit pop;
    bit acc;
    pop = (m_fifo.size() != 0) && (m_cyc >= m_free_at);
    acc = (m_fifo.size() < 4) || pop;
    if (pop) begin
      exp_q.push_back(m_fifo.pop_front());
      m_free_at = m_cyc + FRAME;
    end
    if (we) begin
      if (a == 16'h1000) m_leds = d[7:0];
      else if (a == 16'h2000) begin
        if (acc) m_fifo.push_back(d[7:0]);
        else m_ovf = 1'b1;
      end
      else if (a == 16'h2001) m_ovf = 1'b0;
    end
    m_tick = (we && a == 16'h3000) ? d : m_tick + 16'h0001;
    m_cyc++;
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    logic busy;
    busy = (m_fifo.size() != 0) || (m_cyc <= m_free_at);
    if (a == 16'h1000) return {8'h00, m_leds};
    if (a == 16'h2001) return {10'b0, 3'(m_fifo.size()), m_ovf, (m_fifo.size() == 4), busy};
    if (a == 16'h3000) return m_tick;
    return 16'h0000;
  endfunction

  // Called at a falling edge; drives one cycle's inputs and returns at the next falling edge.
  task automatic step(input logic we, input logic [15:0] a, input logic [15:0] d);
    io_write_enable = we;
    io_address      = a;
    io_write_data   = d;
    @(posedge clock);
    model_edge(we, a, d);
    @(negedge clock);
    io_write_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic rd_k(input string name, input logic [15:0] a, input logic [15:0] exp);
    io_write_enable = 1'b0;
    io_address      = a;
    #1;
    chk(name, io_read_data, exp);
  endtask

  task automatic rd_m(input string name, input logic [15:0] a);
    rd_k(name, a, model_read(a));
  endtask

  function automatic logic exp_bit(input int k, input logic [7:0] v);
    int idx;
    idx = (k - 1) / CPB;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return v[idx-1];
  endfunction

  // UART receiver: samples each bit half a clock after it begins, then checks the byte against the scoreboard.
  initial begin : monitor
    int ep;
    int t0;
    logic [7:0] b;
    logic stop_bit;
    byte unsigned e;
    forever begin
      @(negedge clock);
      if (active_low_reset && uart_tx === 1'b0) begin
        ep = epoch;
        t0 = pcount;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clock);
        stop_bit = uart_tx;
        // A frame cut short by reset is expected to be garbage; discard it.
        if (ep == epoch && active_low_reset) begin
          starts_q.push_back(t0);
          rx_q.push_back(b);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected: got byte %h, expected no frame", b);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", b, e);
          end
          chk("rx_stop", stop_bit, 1);
        end
      end
    end
  end

  initial begin : main
    int lows;
    int r;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] ra;
    model_reset();
    repeat (3) @(negedge clock);
    #1;
    chk("rst_leds", leds, 8'h00);
    chk("rst_tx", uart_tx, 1);
    rd_k("rst_status", 16'h2001, 16'h0000);
    rd_k("rst_tick", 16'h3000, 16'h0000);
    @(negedge clock);
    active_low_reset = 1'b1;
    step(1'b0, 16'h0000, 16'h0000);
    rd_k("tick_first", 16'h3000, 16'h0001);

    // LED and full-address decode
    step(1'b1, 16'h1000, 16'h12A5);
    chk("led_val", leds, 8'hA5);
    rd_k("led_rd", 16'h1000, 16'h00A5);
    step(1'b1, 16'h1234, 16'hFFFF);
    chk("led_keep", leds, 8'hA5);
    rd_k("unmapped_rd", 16'h1234, 16'h0000);
    rd_m("status_idle", 16'h2001);

    // Tick counter load and wrap
    step(1'b1, 16'h3000, 16'hFFFE);
    rd_k("tick_load", 16'h3000, 16'hFFFE);
    idle(1);
    rd_k("tick_ffff", 16'h3000, 16'hFFFF);
    idle(1);
    rd_k("tick_wrap", 16'h3000, 16'h0000);

    // Single byte, cycle-exact line check
    step(1'b1, 16'h2000, 16'h0055);
    chk("tx_high_at_write", uart_tx, 1);
    for (int k = 1; k <= FRAME; k++) begin
      idle(1);
      chk("tx_bit", uart_tx, exp_bit(k, 8'h55));
      if (k == FRAME) rd_k("busy_last_clk", 16'h2001, 16'h0001);
    end
    idle(1);
    rd_k("busy_clear", 16'h2001, 16'h0000);

    // FIFO full and overflow
    starts_q.delete();
    rx_q.delete();
    for (int i = 1; i <= 6; i++) step(1'b1, 16'h2000, 16'(i));
    rd_k("ovf_status", 16'h2001, 16'h0027);
    step(1'b1, 16'h2001, 16'h0000);
    rd_k("ovf_cleared", 16'h2001, 16'h0023);
    idle(5 * FRAME + 10);
    rd_k("ovf_drained", 16'h2001, 16'h0000);
    chk("ovf_frames", rx_q.size(), 5);
    if (rx_q.size() == 5) chk("ovf_last_byte", rx_q[4], 8'h05);
    for (int i = 1; i < starts_q.size(); i++) chk("frame_spacing", starts_q[i] - starts_q[i-1], FRAME);

    // Push at full, coinciding with a pop
    rx_q.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 16'h2000, 16'(8'h11 + i));
    idle(FRAME - 4);
    step(1'b1, 16'h2000, 16'h0077);
    rd_k("full_pop_status", 16'h2001, 16'h0023);
    idle(5 * FRAME + 10);
    chk("full_pop_frames", rx_q.size(), 6);
    if (rx_q.size() == 6) chk("full_pop_last", rx_q[5], 8'h77);
    rd_k("full_pop_drained", 16'h2001, 16'h0000);

    // Reset mid-frame during data bit 3 of 0xF0, with two bytes queued behind it
    step(1'b1, 16'h2000, 16'h00F0);
    step(1'b1, 16'h2000, 16'h0011);
    step(1'b1, 16'h2000, 16'h0022);
    idle(16);
    chk("pre_reset_bit3", uart_tx, 0);
    #2;
    active_low_reset = 1'b0;
    #1;
    chk("rst_async_tx", uart_tx, 1);
    model_reset();
    epoch++;
    repeat (2) @(negedge clock);
    active_low_reset = 1'b1;
    rd_k("rst_status_after", 16'h2001, 16'h0000);
    chk("rst_leds_after", leds, 8'h00);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("no_frame_after_reset", lows, 0);
    rd_m("tick_after_reset", 16'h3000);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      d = 16'($urandom_range(0, 16'hFFFF));
      if (r < 35)      step(1'b0, 16'h0000, d);
      else if (r < 55) step(1'b1, 16'h2000, d);
      else if (r < 60) step(1'b1, 16'h2001, d);
      else if (r < 70) step(1'b1, 16'h1000, d);
      else if (r < 74) step(1'b1, 16'h3000, d);
      else if (r < 80) begin
        a = 16'($urandom_range(0, 16'hFFFF));
        step(1'b1, a, d);
      end
      else step(1'b0, 16'h0000, d);
      case ($urandom_range(0, 4))
        0:       ra = 16'h1000;
        1:       ra = 16'h2000;
        2:       ra = 16'h2001;
        3:       ra = 16'h3000;
        default: ra = 16'($urandom_range(0, 16'hFFFF));
      endcase
      rd_m("rand_rd", ra);
      chk("rand_leds", leds, m_leds);
    end
    step(1'b1, 16'h2001, 16'h0000);
    idle(6 * FRAME);
    rd_k("final_status", 16'h2001, 16'h0000);
    chk("exp_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the core data word width.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434, the UART bit period in clocks (minimum 2).
REQ-003 SHALL have port clock  input  1  the rising-edge system clock.
REQ-004 SHALL have port active_low_reset  input  1  the asynchronous, active-low reset.
REQ-005 SHALL have port io_address  input  16  the core memory_address (next data-stack top).
REQ-006 SHALL have port io_write_enable  input  1  the core I/O write strobe.
REQ-007 SHALL have port io_write_data  input  WIDTH  the core data_out.
REQ-008 SHALL have port io_read_data  output  WIDTH  the data driven back to the core io_data_in.
REQ-009 SHALL have port leds  output  8  the LED register contents.
REQ-010 SHALL have port uart_tx  output  1  the serial transmit line, 8N1, idle high.

Function
REQ-011 SHALL capture all writes on the rising clock edge where io_write_enable=1, decoded on the full 16-bit io_address.
REQ-012 SHALL drive io_read_data combinationally from io_address and current register state, with zero added latency.
REQ-013 SHALL map 0x1000 as LED: a write loads io_write_data[7:0] into leds; a read returns {0, leds}.
REQ-014 SHALL map 0x2000 as TX data: a write pushes io_write_data[7:0] into the TX FIFO; a read returns 0.
REQ-015 SHALL map 0x2001 as TX status: a read returns bit0 busy, bit1 full, bit2 overflow, bits[5:3] FIFO count (0-4), other bits 0; a write of any value clears overflow.
REQ-016 SHALL define busy as (FIFO count != 0) OR (TX state != IDLE).
REQ-017 SHALL map 0x3000 as the tick counter: WIDTH bits, +1 every clock, wrapping from all-ones to 0; a read returns the counter; a write loads io_write_data, taking priority over the increment in that cycle.
REQ-018 SHALL return 0 on reads of unmapped addresses and ignore writes to them.
REQ-019 SHALL implement the TX FIFO as 4 entries of 8 bits, first in first out.
REQ-020 SHALL accept a push when count<4, or when count=4 and a pop occurs on the same edge.
REQ-021 SHALL, on a rejected push, drop the byte, leave the FIFO unchanged, and set the sticky overflow flag.
REQ-022 SHALL implement TX state machine states IDLE, START, DATA, STOP.
REQ-023 SHALL move IDLE->START on an edge where the FIFO is non-empty, popping the head byte into the shift register on that edge.
REQ-024 SHALL hold each state for exactly CLKS_PER_BIT clocks, timed by a bit counter.
REQ-025 SHALL drive uart_tx low in START, shift register bit[0] in DATA (LSB first, 8 bits, then DATA->STOP), and high in STOP and IDLE.
REQ-026 SHALL move STOP->START directly at the end of the STOP bit when the FIFO is non-empty (popping on that edge, no idle gap), and otherwise STOP->IDLE.
REQ-027 SHALL give a byte pushed into an empty FIFO in IDLE a uart_tx falling edge one clock after the write edge.
REQ-028 SHALL give each frame a duration of exactly 10*CLKS_PER_BIT clocks.
REQ-029 SHALL register uart_tx as a flop output and keep it glitch-free.

Reset
REQ-030 SHALL take the following values while active_low_reset=0, regardless of clock: leds=0, uart_tx=1, FIFO empty, overflow=0, tick counter=0, TX state IDLE, bit counter=0.
REQ-031 SHALL abort any frame in progress on a reset assertion mid-frame; uart_tx SHALL return high immediately and queued bytes SHALL be discarded.
REQ-032 SHALL act on the first rising clock edge after reset deassertion, on which the tick counter increments to 1.

Verification (CLKS_PER_BIT=4)
REQ-033 SHALL cover LED and decode: write 0x1000<=0x12A5 -> leds=0xA5 and a read of 0x1000 returns 0x00A5; write 0x1234<=0xFFFF -> no state change and a read of 0x1234 returns 0.
REQ-034 SHALL cover a single byte: write 0x2000<=0x0055 in IDLE -> uart_tx low 1 clock later, bit sequence 0,1,0,1,0,1,0,1,0,1 at 4 clocks each, then busy=0 after 40 clocks.
REQ-035 SHALL cover FIFO full/overflow: 6 back-to-back pushes 0x01..0x06 -> status reads full=1, count=4, overflow=1; frames 0x01..0x05 are sent back-to-back with no idle gap; 0x06 is lost; a write to 0x2001 clears overflow.
REQ-036 SHALL cover push at full with a simultaneous pop: count=4 with the pop edge coinciding with a push of 0x77 -> byte accepted, overflow stays 0, 0x77 is sent last.
REQ-037 SHALL cover the tick counter: write 0x3000<=0xFFFE -> reads return 0xFFFF then 0x0000 on the following clocks; a write on the same edge as the increment loads the written value exactly.
REQ-038 SHALL cover reset mid-frame: assert active_low_reset during the DATA bit 3 of byte 0xF0 with 2 bytes queued -> uart_tx=1 asynchronously, status reads 0 after release, and no further frame is sent.
